// File: rtl/csr_shadow_pkg.sv
// Shared types and helpers for the shadow/active CSR bank.
package csr_shadow_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  // Widest word the strobe helper handles; callers zero-extend and truncate.
  localparam int MAX_W    = 256;
  localparam int MAX_STRB = MAX_W / 8;

  function automatic logic [MAX_W-1:0] strb_apply(input logic [MAX_W-1:0]    old_w,
                                                  input logic [MAX_W-1:0]    new_w,
                                                  input logic [MAX_STRB-1:0] strb);
    logic [MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_STRB; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/csr_strb_merge.sv
// Byte-strobe merge of a new word into an old word.
module csr_strb_merge
  import csr_shadow_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STRB_W = WIDTH / 8
) (
  input  logic [WIDTH-1:0]  old_word,
  input  logic [WIDTH-1:0]  new_word,
  input  logic [STRB_W-1:0] strb,
  output logic [WIDTH-1:0]  merged
);

  assign merged = WIDTH'(strb_apply(MAX_W'(old_word), MAX_W'(new_word), MAX_STRB'(strb)));

endmodule

// File: rtl/csr_shadow_bank.sv
// Shadow/active CSR bank: byte-strobed writes to shadow, commit copies
// shadow -> active one register per cycle, reads return the active copy.
module csr_shadow_bank
  import csr_shadow_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = 'hABCD,
  localparam int              ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH/8-1:0] wr_strb,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data_valid,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              commit,
  input  logic [DEPTH-1:0]  lock_set,
  output logic [DEPTH-1:0]  locked,
  output logic              busy,
  output logic              err
);

  localparam int                STRB_W   = $bits(wr_data) / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             idx_q;
  logic [DEPTH-1:0][WIDTH-1:0]   shadow_q, active_q;
  logic [WIDTH-1:0]              merged;
  logic                          wr_acc, wr_in_rng, wr_bad, rd_in_rng;

  assign wr_ready  = (state_q == IDLE);
  assign busy      = (state_q == COMMIT);
  assign wr_acc    = wr_valid && wr_ready;
  assign wr_in_rng = 32'(wr_addr) < DEPTH;
  assign rd_in_rng = 32'(rd_addr) < DEPTH;
  // Range is checked first so an out-of-range address never looks at locked.
  assign wr_bad    = wr_acc && (!wr_in_rng || locked[wr_addr]);

  csr_strb_merge #(
    .WIDTH  (WIDTH),
    .STRB_W (STRB_W)
  ) u_merge (
    .old_word (shadow_q[wr_addr]),
    .new_word (wr_data),
    .strb     (wr_strb),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (commit) state_d = COMMIT;
      COMMIT: if (idx_q == LAST_IDX) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      locked        <= '0;
      err           <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      shadow_q      <= {DEPTH{RESET_VAL}};
      active_q      <= {DEPTH{RESET_VAL}};
    end else begin
      state_q       <= state_d;
      locked        <= locked | lock_set;
      err           <= wr_bad || (rd_valid && !rd_in_rng);
      rd_data_valid <= rd_valid;
      // Read samples active before this edge's copy lands.
      if (rd_valid) rd_data <= rd_in_rng ? active_q[rd_addr] : '0;
      if (wr_acc && !wr_bad) shadow_q[wr_addr] <= merged;
      if (busy) begin
        active_q[idx_q] <= shadow_q[idx_q];
        idx_q           <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end
  end

endmodule
